// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline buffers: the occupancy
// state encoding, the machine word size, the NOP encoding, and the bit
// layout of the EX/MEM bundle.
package pipe_pkg;

    // Occupancy of a stage buffer: no word, main entry only, main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    localparam int WORD_W = 32;

    // An all-zero instruction word decodes as NOP, so bubbles are all zeros.
    localparam logic [WORD_W-1:0] NOP_WORD = '0;

    // EX/MEM bundle layout. IR sits in the low word, so a cleared bundle
    // always carries a NOP instruction.
    localparam int EXMEM_IR_LSB      = 0;
    localparam int EXMEM_PC8_LSB     = EXMEM_IR_LSB     + WORD_W;
    localparam int EXMEM_ALUOUT_LSB  = EXMEM_PC8_LSB    + WORD_W;
    localparam int EXMEM_RT_LSB      = EXMEM_ALUOUT_LSB + WORD_W;
    localparam int EXMEM_XALUOUT_LSB = EXMEM_RT_LSB     + WORD_W;
    localparam int EXMEM_W           = EXMEM_XALUOUT_LSB + WORD_W;

    // Pull one 32-bit field out of an EX/MEM bundle.
    function automatic logic [WORD_W-1:0] exmem_field(
        input logic [EXMEM_W-1:0] bus,
        input int                 lsb
    );
        return bus[lsb +: WORD_W];
    endfunction

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter with synchronous clear. The count sticks at its
// all-ones value instead of wrapping, so a long stall never reads as short.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Add one unless already at the ceiling.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : (v + CNT_ONE);
    endfunction

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic pipeline-stage register with valid/ready handshake, flush and an
// optional skid entry. With SKID=1 the upstream ready is a flop, breaking
// the ready path between stages; with SKID=0 it is a single latch whose
// ready passes the downstream ready straight through when full.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int          WIDTH = 160,
    parameter int unsigned SKID  = 1,
    parameter int          CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    buf_state_e       state_q;
    buf_state_e       state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             out_valid_q;
    logic             out_valid_d;

    logic             accept;
    logic             issue;
    logic             stalled;

    assign accept  = in_valid && in_ready;
    assign issue   = out_valid_q && out_ready;
    assign stalled = out_valid_q && !out_ready;

    // Occupancy and entry update. Reset and flush both empty the buffer and
    // discard any word offered in the same cycle; a word issued in that
    // cycle has already been taken downstream.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (reset || flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && issue) begin
                        main_d = in_data;
                    end else if (accept && (SKID != 0)) begin
                        skid_d  = in_data;
                        state_d = TWO;
                    end else if (issue) begin
                        main_d  = '0;
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (issue) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
        out_valid_d = (state_d != EMPTY);
    end

    // State, entries and registered valid.
    always_ff @(posedge clk) begin
        state_q     <= state_d;
        main_q      <= main_d;
        skid_q      <= skid_d;
        out_valid_q <= out_valid_d;
    end

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;
            logic in_ready_d;

            // Ready drops only once the skid entry is occupied.
            always_comb begin
                in_ready_d = (state_d != TWO);
            end

            // Registered upstream ready.
            always_ff @(posedge clk) begin
                in_ready_q <= in_ready_d;
            end

            assign in_ready = in_ready_q;
        end else begin : g_single
            assign in_ready = !out_valid_q || out_ready;
        end
    endgenerate

    // Bubbles are presented as all-zero (NOP) words.
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? main_q : '0;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .clr (reset),
        .inc (stalled),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: three instances (skid with a wide counter, skid
// with a 4-bit counter, single-entry) driven side by side, each compared
// every cycle against a small FIFO-occupancy reference model.
module tb_pipe_stage_buf;

    localparam int W = 32;
    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_i       [N];
    logic         flush_i     [N];
    logic         in_valid_i  [N];
    logic         out_ready_i [N];
    logic [W-1:0] in_data_i   [N];
    logic         in_ready_o  [N];
    logic         out_valid_o [N];
    logic [W-1:0] out_data_o  [N];
    logic [15:0]  cnt0;
    logic [3:0]   cnt1;
    logic [15:0]  cnt2;

    pipe_stage_buf #(.WIDTH(W), .SKID(1), .CNT_W(16)) u_skid (
        .clk(clk), .reset(rst_i[0]), .flush(flush_i[0]),
        .in_valid(in_valid_i[0]), .in_ready(in_ready_o[0]), .in_data(in_data_i[0]),
        .out_valid(out_valid_o[0]), .out_ready(out_ready_i[0]), .out_data(out_data_o[0]),
        .stall_cnt(cnt0)
    );

    pipe_stage_buf #(.WIDTH(W), .SKID(1), .CNT_W(4)) u_sat (
        .clk(clk), .reset(rst_i[1]), .flush(flush_i[1]),
        .in_valid(in_valid_i[1]), .in_ready(in_ready_o[1]), .in_data(in_data_i[1]),
        .out_valid(out_valid_o[1]), .out_ready(out_ready_i[1]), .out_data(out_data_o[1]),
        .stall_cnt(cnt1)
    );

    pipe_stage_buf #(.WIDTH(W), .SKID(0), .CNT_W(16)) u_single (
        .clk(clk), .reset(rst_i[2]), .flush(flush_i[2]),
        .in_valid(in_valid_i[2]), .in_ready(in_ready_o[2]), .in_data(in_data_i[2]),
        .out_valid(out_valid_o[2]), .out_ready(out_ready_i[2]), .out_data(out_data_o[2]),
        .stall_cnt(cnt2)
    );

    // Reference model: words held (oldest first), stall count, per-instance config.
    int           m_n    [N];
    logic [W-1:0] m_buf  [N][2];
    int           m_cnt  [N];
    int           m_max  [N] = '{65535, 15, 65535};
    bit           m_skid [N] = '{1'b1, 1'b1, 1'b0};
    bit           seq_mode;
    bit           accepted [N];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] dut_cnt(input int i);
        case (i)
            0:       return {48'b0, cnt0};
            1:       return {60'b0, cnt1};
            default: return {48'b0, cnt2};
        endcase
    endfunction

    // One clock: compare at the falling edge, advance the model, then after
    // the rising edge give the next fresh word to any source that was accepted.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            bit           ov;
            bit           ir;
            bit           acc;
            bit           iss;
            logic [W-1:0] od;
            ov  = (m_n[i] > 0);
            od  = ov ? m_buf[i][0] : '0;
            ir  = m_skid[i] ? (m_n[i] < 2) : ((m_n[i] == 0) || out_ready_i[i]);
            acc = 1'b0;
            iss = 1'b0;
            check($sformatf("u%0d.out_valid", i), 64'(out_valid_o[i]), 64'(ov));
            check($sformatf("u%0d.out_data", i),  64'(out_data_o[i]),  64'(od));
            check($sformatf("u%0d.in_ready", i),  64'(in_ready_o[i]),  64'(ir));
            check($sformatf("u%0d.stall_cnt", i), dut_cnt(i),          64'(m_cnt[i]));
            if (rst_i[i]) begin
                m_n[i]   = 0;
                m_cnt[i] = 0;
            end else begin
                if (ov && !out_ready_i[i] && (m_cnt[i] < m_max[i])) m_cnt[i]++;
                if (flush_i[i]) begin
                    m_n[i] = 0;
                end else begin
                    acc = in_valid_i[i] && ir;
                    iss = ov && out_ready_i[i];
                    if (iss) begin
                        m_buf[i][0] = m_buf[i][1];
                        m_n[i]--;
                    end
                    if (acc) begin
                        m_buf[i][m_n[i]] = in_data_i[i];
                        m_n[i]++;
                    end
                end
            end
            accepted[i] = acc;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (accepted[i]) in_data_i[i] = seq_mode ? in_data_i[i] + 1 : W'($urandom);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        seq_mode = 1'b0;
        for (int i = 0; i < N; i++) begin
            rst_i[i] = 1'b1; flush_i[i] = 1'b0; in_valid_i[i] = 1'b0;
            out_ready_i[i] = 1'b1; in_data_i[i] = W'($urandom);
            m_n[i] = 0; m_cnt[i] = 0; accepted[i] = 1'b0;
            m_buf[i][0] = '0; m_buf[i][1] = '0;
        end
        @(posedge clk);
        #1;
        step();
        for (int i = 0; i < N; i++) rst_i[i] = 1'b0;

        // Idle after reset.
        repeat (5) step();

        // Streaming 0x01..0x10 at full rate.
        seq_mode = 1'b1;
        in_data_i[0] = 32'h1; in_valid_i[0] = 1'b1;
        in_data_i[2] = 32'h1; in_valid_i[2] = 1'b1;
        repeat (16) step();
        in_valid_i[0] = 1'b0; in_valid_i[2] = 1'b0;
        seq_mode = 1'b0;
        repeat (2) step();

        // Backpressure: A, B fill the buffer; C held off until release.
        out_ready_i[0] = 1'b0; in_valid_i[0] = 1'b1;
        step(); step();
        check("bp.in_ready_low", 64'(in_ready_o[0]), 64'd0);
        repeat (3) step();
        out_ready_i[0] = 1'b1;
        repeat (2) step();
        in_valid_i[0] = 1'b0;
        repeat (3) step();

        // Flush while full, with a word offered in the flush cycle.
        out_ready_i[0] = 1'b0; in_valid_i[0] = 1'b1;
        step(); step();
        flush_i[0] = 1'b1;
        step();
        flush_i[0] = 1'b0; in_valid_i[0] = 1'b0;
        check("flush.out_valid", 64'(out_valid_o[0]), 64'd0);
        check("flush.out_data",  64'(out_data_o[0]),  64'd0);
        out_ready_i[0] = 1'b1;
        repeat (2) step();

        // Stall counter saturation on the 4-bit instance, then reset.
        out_ready_i[1] = 1'b0; in_valid_i[1] = 1'b1;
        step();
        in_valid_i[1] = 1'b0;
        repeat (20) step();
        check("sat.stall_cnt", dut_cnt(1), 64'd15);
        rst_i[1] = 1'b1;
        step();
        rst_i[1] = 1'b0;
        check("sat.after_reset", dut_cnt(1), 64'd0);
        out_ready_i[1] = 1'b1;

        // Single-entry mode with alternating downstream ready.
        in_valid_i[2] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            out_ready_i[2] = c[0];
            step();
        end
        in_valid_i[2] = 1'b0; out_ready_i[2] = 1'b1;
        repeat (2) step();

        // Random traffic with occasional flush and reset.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                in_valid_i[i]  = ($urandom % 2) == 0;
                out_ready_i[i] = ($urandom % 4) != 0;
                flush_i[i]     = ($urandom % 16) == 0;
                rst_i[i]       = ($urandom % 64) == 0;
            end
            step();
        end
        for (int i = 0; i < N; i++) begin
            in_valid_i[i] = 1'b0; out_ready_i[i] = 1'b1;
            flush_i[i] = 1'b0; rst_i[i] = 1'b0;
        end
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
